// File: rtl/ring_node_arbiter.sv
// Per-node slot arbiter for the slotted unidirectional ring: ejects, forwards or
// replaces the arriving slot, and throttles upstream when local injection starves.
module ring_node_arbiter #(
   parameter int  NUM_PROC     = 8,
   parameter int  NODE_ID      = 0,
   parameter int  STARVE_LIMIT = 4,
   parameter int  PID_W        = 32,
   localparam int ID_W         = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             ring_in_valid,
   input  logic [ID_W-1:0]  ring_in_dest,
   input  logic [PID_W-1:0] ring_in_pid,
   input  logic             inj_valid,
   input  logic [ID_W-1:0]  inj_dest,
   input  logic [PID_W-1:0] inj_pid,
   output logic             inj_pop,
   input  logic             throttle_in,
   output logic             ring_out_valid,
   output logic [ID_W-1:0]  ring_out_dest,
   output logic [PID_W-1:0] ring_out_pid,
   output logic             throttle_out,
   output logic             recieved,
   output logic [PID_W-1:0] pidRecieved,
   output logic [15:0]      starve_cnt,
   output logic [1:0]       o_dbg_state
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_STARVED = 2'd2;

   localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIMIT);
   localparam logic [ID_W-1:0]  MY_ID = ID_W'(NODE_ID);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_blk_cnt;
   logic             r_throttle;
   logic [15:0]      r_starve_cnt;
   logic             r_out_valid;
   logic [ID_W-1:0]  r_out_dest;
   logic [PID_W-1:0] r_out_pid;
   logic             r_rcv;
   logic [PID_W-1:0] r_pidr;

   logic             w_eject;
   logic             w_slot_free;
   logic             w_loop;
   logic             w_inj_ok;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_blk_nxt;

   // Injection handshake: the FIFO head is consumed in exactly the cycles where
   // inj_pop is high; inj_pop only rises with inj_valid and is held low in reset.
   assign w_eject     = ring_in_valid && (ring_in_dest == MY_ID);
   assign w_slot_free = !ring_in_valid || w_eject;
   assign w_loop      = (inj_dest == MY_ID);
   // A loopback packet cannot share the delivery port with an ejecting slot.
   assign w_inj_ok    = inj_valid && w_slot_free && !throttle_in && !(w_loop && w_eject);
   assign inj_pop     = rst_l && w_inj_ok;

   always_comb begin
      w_state_nxt = r_state;
      w_blk_nxt   = r_blk_cnt;
      if (w_inj_ok || !inj_valid) begin
         w_state_nxt = S_IDLE;
         w_blk_nxt   = '0;
      end else begin
         if (r_blk_cnt != LIM_C) begin
            w_blk_nxt = r_blk_cnt + CNT_W'(1);
         end
         w_state_nxt = (w_blk_nxt == LIM_C) ? S_STARVED : S_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_state      <= S_IDLE;
         r_blk_cnt    <= '0;
         r_throttle   <= 1'b0;
         r_starve_cnt <= 16'd0;
         r_out_valid  <= 1'b0;
         r_out_dest   <= '0;
         r_out_pid    <= '0;
         r_rcv        <= 1'b0;
         r_pidr       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_blk_cnt  <= w_blk_nxt;
         r_throttle <= (w_state_nxt == S_STARVED);
         if ((r_state == S_STARVED) && (r_starve_cnt != 16'hFFFF)) begin
            r_starve_cnt <= r_starve_cnt + 16'd1;
         end
         if (w_inj_ok && !w_loop) begin
            r_out_valid <= 1'b1;
            r_out_dest  <= inj_dest;
            r_out_pid   <= inj_pid;
         end else if (ring_in_valid && !w_eject) begin
            r_out_valid <= 1'b1;
            r_out_dest  <= ring_in_dest;
            r_out_pid   <= ring_in_pid;
         end else begin
            r_out_valid <= 1'b0;
            r_out_dest  <= '0;
            r_out_pid   <= '0;
         end
         r_rcv <= w_eject || (w_inj_ok && w_loop);
         if (w_eject) begin
            r_pidr <= ring_in_pid;
         end else if (w_inj_ok && w_loop) begin
            r_pidr <= inj_pid;
         end
      end
   end

   assign ring_out_valid = r_out_valid;
   assign ring_out_dest  = r_out_dest;
   assign ring_out_pid   = r_out_pid;
   assign throttle_out   = r_throttle;
   assign recieved       = r_rcv;
   assign pidRecieved    = r_pidr;
   assign starve_cnt     = r_starve_cnt;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ring_node_arbiter.sv
// Bench for ring_node_arbiter (node 2 of 8): stimulus pushes per-cycle expectations
// from a slot-rule model; a monitor pops and compares one record per clock.
module tb_ring_node_arbiter;

   localparam int NODE  = 2;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic        is_rst;
      logic        pop;
      logic        ov;
      logic [2:0]  od;
      logic [31:0] op;
      logic        rcv;
      logic [31:0] pidr;
      logic        thr;
      logic [15:0] sc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        ring_in_valid = 1'b0;
   logic [2:0]  ring_in_dest = '0;
   logic [31:0] ring_in_pid = '0;
   logic        inj_valid = 1'b0;
   logic [2:0]  inj_dest = '0;
   logic [31:0] inj_pid = '0;
   logic        inj_pop;
   logic        throttle_in = 1'b0;
   logic        ring_out_valid;
   logic [2:0]  ring_out_dest;
   logic [31:0] ring_out_pid;
   logic        throttle_out;
   logic        recieved;
   logic [31:0] pidRecieved;
   logic [15:0] starve_cnt;
   logic [1:0]  o_dbg_state;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // reference model state: consecutive blocked cycles, starved-cycle count, last delivered id
   int          m_blocked = 0;
   int          m_starve = 0;
   logic [31:0] m_pidr = '0;

   ring_node_arbiter #(
      .NUM_PROC(8), .NODE_ID(NODE), .STARVE_LIMIT(LIMIT), .PID_W(32)
   ) dut (
      .clk(clk), .rst_l(rst_l),
      .ring_in_valid(ring_in_valid), .ring_in_dest(ring_in_dest), .ring_in_pid(ring_in_pid),
      .inj_valid(inj_valid), .inj_dest(inj_dest), .inj_pid(inj_pid), .inj_pop(inj_pop),
      .throttle_in(throttle_in),
      .ring_out_valid(ring_out_valid), .ring_out_dest(ring_out_dest), .ring_out_pid(ring_out_pid),
      .throttle_out(throttle_out), .recieved(recieved), .pidRecieved(pidRecieved),
      .starve_cnt(starve_cnt), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic riv, input logic [2:0] rid,
                        input logic [31:0] rpid, input logic iv, input logic [2:0] idst,
                        input logic [31:0] ipid, input logic thr);
      exp_t e;
      bit   ej, lp, pop;
      @(negedge clk);
      rst_l = rst; ring_in_valid = riv; ring_in_dest = rid; ring_in_pid = rpid;
      inj_valid = iv; inj_dest = idst; inj_pid = ipid; throttle_in = thr;
      e = '0;
      if (!rst) begin
         m_blocked = 0;
         m_starve  = 0;
         m_pidr    = '0;
         e.is_rst  = 1'b1;
      end else begin
         ej  = riv && (int'(rid) == NODE);
         lp  = (int'(idst) == NODE);
         pop = iv && (!riv || ej) && !thr && !(lp && ej);
         e.pop = pop;
         if (pop && !lp) begin
            e.ov = 1'b1; e.od = idst; e.op = ipid;
         end else if (riv && !ej) begin
            e.ov = 1'b1; e.od = rid; e.op = rpid;
         end
         e.rcv = ej || (pop && lp);
         if (ej) m_pidr = rpid;
         else if (pop && lp) m_pidr = ipid;
         if (m_blocked >= LIMIT && m_starve < 65535) m_starve++;
         if (pop || !iv) m_blocked = 0;
         else m_blocked++;
      end
      e.pidr = m_pidr;
      e.sc   = 16'(m_starve);
      e.thr  = (m_blocked >= LIMIT);
      exp_q.push_back(e);
   endtask

   // monitor: one expectation per clock, sampled just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inj_pop", 32'(inj_pop), 32'(e.pop));
            check("ring_out_valid", 32'(ring_out_valid), 32'(e.ov));
            if (e.ov || e.is_rst) begin
               check("ring_out_dest", 32'(ring_out_dest), 32'(e.od));
               check("ring_out_pid", ring_out_pid, e.op);
            end
            check("recieved", 32'(recieved), 32'(e.rcv));
            check("pidRecieved", pidRecieved, e.pidr);
            check("throttle_out", 32'(throttle_out), 32'(e.thr));
            check("starve_cnt", 32'(starve_cnt), 32'(e.sc));
            if (e.is_rst) check("state_idle", 32'(o_dbg_state), 32'd0);
         end
      end
   end

   initial begin
      // reset with random inputs, then first injection
      repeat (2) drive(1'b0, 1'($urandom), 3'($urandom), $urandom, 1'($urandom),
                       3'($urandom), $urandom, 1'($urandom));
      drive(1'b1, 0, 3'd0, 32'h0, 1, 3'd3, 32'h11, 0);
      // eject and slot reuse in the same cycle
      drive(1'b1, 1, 3'd2, 32'hAB, 1, 3'd5, 32'h22, 0);
      // starvation under continuous transit, then release
      for (int i = 0; i < 9; i++) drive(1'b1, 1, 3'd6, 32'h600 + i, 1, 3'd5, 32'h33, 0);
      drive(1'b1, 0, 3'd0, 32'h0, 1, 3'd5, 32'h33, 0);
      drive(1'b1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0);
      // loopback blocked by eject, then delivered on an idle ring
      drive(1'b1, 1, 3'd2, 32'h8, 1, 3'd2, 32'h7, 0);
      drive(1'b1, 0, 3'd0, 32'h0, 1, 3'd2, 32'h7, 0);
      drive(1'b1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0);
      // throttle_in: suppress injection only
      drive(1'b1, 0, 3'd0, 32'h0, 1, 3'd5, 32'h44, 1);
      drive(1'b1, 1, 3'd4, 32'h4444, 1, 3'd5, 32'h44, 1);
      drive(1'b1, 1, 3'd2, 32'h55, 1, 3'd5, 32'h44, 1);
      // starve, then reset in STARVED
      for (int i = 0; i < 7; i++) drive(1'b1, 1, 3'd7, 32'h700 + i, 1, 3'd1, 32'h66, 0);
      drive(1'b0, 1, 3'd7, 32'h0, 1, 3'd1, 32'h66, 0);
      drive(1'b1, 0, 3'd0, 32'h0, 1, 3'd1, 32'h66, 0);
      // randomized traffic, light then dense, with rare resets
      for (int i = 0; i < 600; i++) begin
         int dense;
         dense = (i >= 300) ? 19 : 3;
         drive(1'($urandom_range(0, 99) != 0),
               1'($urandom_range(0, dense) != 0), 3'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 4) == 0));
      end
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
